// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ command sources.
// Latches the winner's command/ss/mode, triggers the master, acks on completion and flags hung transfers.
module spi_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [16*NUM_REQ-1:0] i_req_command,
  input  logic [10*NUM_REQ-1:0] i_req_ss,
  input  logic [NUM_REQ-1:0]    i_req_cpol,
  input  logic [NUM_REQ-1:0]    i_req_cpha,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic [NUM_REQ-1:0]    o_ack,
  output logic [15:0]           o_command,
  output logic [9:0]            o_ss,
  output logic                  o_cpol,
  output logic                  o_cpha,
  output logic                  o_trigger,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_timeout_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int CW = (TW > GW) ? TW : GW;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_idx;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_ack;
  logic [15:0]         r_command;
  logic [9:0]          r_ss;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_trigger;
  logic                r_busy;
  logic                r_timeout_err;

  logic                w_found;
  logic [PW-1:0]       w_idx;

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int            cand;
    logic [PW-1:0] c;
    w_found = 1'b0;
    w_idx   = '0;
    cand    = 0;
    c       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(r_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      c = PW'(cand);
      if (!w_found && i_req[c]) begin
        w_found = 1'b1;
        w_idx   = c;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ptr         <= '0;
      r_idx         <= '0;
      r_grant       <= '0;
      r_ack         <= '0;
      r_command     <= '0;
      r_ss          <= '0;
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_trigger     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ack     <= '0;
      r_trigger <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found && i_ready) begin
            r_idx     <= w_idx;
            r_grant   <= ONE << w_idx;
            r_command <= i_req_command[16*w_idx +: 16];
            r_ss      <= i_req_ss[10*w_idx +: 10];
            r_cpol    <= i_req_cpol[w_idx];
            r_cpha    <= i_req_cpha[w_idx];
            r_trigger <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A master that never drops ready is taken as having finished instantly.
          if (!i_ready) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CW'(1)) begin
            r_ack   <= r_grant;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (i_ready) begin
            r_ack   <= r_grant;
            r_state <= S_DONE;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
            r_ack         <= r_grant;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_grant   <= '0;
          r_command <= '0;
          r_ss      <= '0;
          r_cpol    <= 1'b0;
          r_cpha    <= 1'b0;
          r_ptr     <= (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
          r_cnt     <= CW'(GAP_CYCLES);
          if (GAP_CYCLES == 0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt <= CW'(1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_ack         = r_ack;
  assign o_command     = r_command;
  assign o_ss          = r_ss;
  assign o_cpol        = r_cpol;
  assign o_cpha        = r_cpha;
  assign o_trigger     = r_trigger;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: two requesters, 10-cycle gap, 100-cycle timeout,
// with a behavioural SPI master that drops ready after trigger.
`timescale 1ns/1ps
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req = 2'b00;
  logic [31:0] req_command = '0;
  logic [19:0] req_ss = '0;
  logic [1:0]  req_cpol = 2'b00;
  logic [1:0]  req_cpha = 2'b00;
  logic        ready;
  logic [1:0]  grant;
  logic [1:0]  ack;
  logic [15:0] command;
  logic [9:0]  ss;
  logic        cpol;
  logic        cpha;
  logic        trigger;
  logic        busy;
  logic        timeout_err;

  int n_pass  = 0;
  int n_total = 0;

  // master model controls
  int   m_lat   = 2;
  logic m_auto  = 1'b1;
  logic m_hang  = 1'b0;
  logic m_level = 1'b1;

  // monitor state
  int          cyc = 0;
  int          trig_cnt = 0;
  int          ack_cnt = 0;
  int          last_trig_cyc = -1;
  int          min_trig_gap = 1000000;
  int          unstable = 0;
  int          leak = 0;
  int          inv_err = 0;
  logic        in_tx = 1'b0;
  logic [15:0] trig_cmd = '0;
  logic [9:0]  trig_ss = '0;
  logic        trig_cpol = 1'b0;
  logic        trig_cpha = 1'b0;
  logic [1:0]  trig_grant_q[$];
  logic [1:0]  ack_q[$];

  spi_arbiter #(
    .NUM_REQ(2),
    .GAP_CYCLES(10),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_req(req),
    .i_req_command(req_command),
    .i_req_ss(req_ss),
    .i_req_cpol(req_cpol),
    .i_req_cpha(req_cpha),
    .o_grant(grant),
    .o_ack(ack),
    .o_command(command),
    .o_ss(ss),
    .o_cpol(cpol),
    .o_cpha(cpha),
    .o_trigger(trigger),
    .i_ready(ready),
    .o_busy(busy),
    .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // SPI master: drop ready when triggered, raise it m_lat cycles later unless hung.
  initial begin
    ready = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (!m_auto) begin
        ready = m_level;
      end else if (trigger) begin
        ready = 1'b0;
        if (!m_hang) begin
          repeat (m_lat) @(negedge clk);
          ready = 1'b1;
        end
      end
    end
  end

  // Observer: one sample per cycle, just after the rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) in_tx = 1'b0;
      if (!$onehot0(grant)) inv_err++;
      if (trigger) begin
        if (!$onehot(grant)) inv_err++;
        trig_cnt++;
        if (last_trig_cyc >= 0 && (cyc - last_trig_cyc) < min_trig_gap)
          min_trig_gap = cyc - last_trig_cyc;
        last_trig_cyc = cyc;
        trig_cmd  = command;
        trig_ss   = ss;
        trig_cpol = cpol;
        trig_cpha = cpha;
        in_tx     = 1'b1;
        trig_grant_q.push_back(grant);
      end else if (in_tx && ({command, ss, cpol, cpha} !== {trig_cmd, trig_ss, trig_cpol, trig_cpha})) begin
        unstable++;
      end
      if (grant == 2'b00 && (ss != 10'd0 || command != 16'd0 || cpol || cpha)) leak++;
      if (|ack) begin
        ack_cnt++;
        ack_q.push_back(ack);
        in_tx = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(3);
    n_total++; if (grant !== 2'b00) $display("FAIL reset_grant got %b want 00", grant); else n_pass++;
    n_total++; if (ack !== 2'b00) $display("FAIL reset_ack got %b want 00", ack); else n_pass++;
    n_total++; if ({trigger, busy, timeout_err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {trigger, busy, timeout_err}); else n_pass++;
    n_total++; if ({command, ss, cpol, cpha} !== 28'd0) $display("FAIL reset_data got %h want 0", {command, ss, cpol, cpha}); else n_pass++;
    rst = 1'b0;
    tick(2);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    int t0, c_ack;
    req_command[15:0] = 16'h2600;
    req_ss[9:0]       = 10'b10;
    req_cpol[0]       = 1'b1;
    req_cpha[0]       = 1'b1;
    m_lat = 20;
    t0 = trig_cnt;
    req = 2'b01;
    for (int k = 0; k < 100 && !ack[0]; k++) tick(1);
    c_ack = cyc;
    n_total++; if (ack !== 2'b01) $display("FAIL single_ack got %b want 01", ack); else n_pass++;
    req = 2'b10;
    req_command[31:16] = 16'h1234;
    req_ss[19:10]      = 10'h001;
    m_lat = 2;
    n_total++; if (trig_cnt - t0 != 1) $display("FAIL single_trig_count got %0d want 1", trig_cnt - t0); else n_pass++;
    n_total++; if ({trig_cmd, trig_ss} !== {16'h2600, 10'b10}) $display("FAIL single_cmd_ss got %h/%h want 2600/002", trig_cmd, trig_ss); else n_pass++;
    n_total++; if ({trig_cpol, trig_cpha} !== 2'b11) $display("FAIL single_mode got %b want 11", {trig_cpol, trig_cpha}); else n_pass++;
    n_total++; if (c_ack - last_trig_cyc != 21) $display("FAIL single_latency got %0d want 21", c_ack - last_trig_cyc); else n_pass++;
    tick(1);
    n_total++; if (ack !== 2'b00) $display("FAIL single_ack_width got %b want 00", ack); else n_pass++;
    tick(5);
    n_total++; if ({grant, busy} !== 3'b001) $display("FAIL single_gap got grant=%b busy=%b want 00/1", grant, busy); else n_pass++;
    for (int k = 0; k < 50 && trig_cnt == t0 + 1; k++) tick(1);
    n_total++; if (last_trig_cyc - c_ack != 12) $display("FAIL single_gap_len got %0d want 12", last_trig_cyc - c_ack); else n_pass++;
    n_total++; if ({grant, command} !== {2'b10, 16'h1234}) $display("FAIL single_next_grant got %b/%h want 10/1234", grant, command); else n_pass++;
    for (int k = 0; k < 50 && !ack[1]; k++) tick(1);
    n_total++; if (ack !== 2'b10) $display("FAIL single_ack1 got %b want 10", ack); else n_pass++;
    req = 2'b00;
    tick(15);
  endtask

  task automatic test_contention();
    int a0;
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    trig_grant_q.delete();
    ack_q.delete();
    min_trig_gap  = 1000000;
    last_trig_cyc = -1;
    m_lat = 2;
    a0 = ack_cnt;
    req = 2'b11;
    for (int k = 0; k < 200 && ack_cnt < a0 + 4; k++) tick(1);
    req = 2'b00;
    n_total++; if (ack_cnt - a0 != 4) $display("FAIL cont_ack_count got %0d want 4", ack_cnt - a0); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= trig_grant_q.size() || trig_grant_q[i] !== exp_g[i])
        $display("FAIL cont_grant%0d got %b want %b", i, (i < trig_grant_q.size()) ? trig_grant_q[i] : 2'bxx, exp_g[i]);
      else n_pass++;
      n_total++;
      if (i >= ack_q.size() || ack_q[i] !== exp_g[i])
        $display("FAIL cont_ack%0d got %b want %b", i, (i < ack_q.size()) ? ack_q[i] : 2'bxx, exp_g[i]);
      else n_pass++;
    end
    n_total++; if (min_trig_gap < 13) $display("FAIL cont_spacing got %0d want >=13", min_trig_gap); else n_pass++;
    tick(15);
  endtask

  task automatic test_not_ready();
    int t0;
    m_auto  = 1'b0;
    m_level = 1'b0;
    tick(2);
    t0 = trig_cnt;
    req_command[15:0] = 16'h0BAD;
    req = 2'b01;
    tick(5);
    n_total++; if ({grant, busy} !== 3'b000) $display("FAIL nready_hold got grant=%b busy=%b want 00/0", grant, busy); else n_pass++;
    n_total++; if (trig_cnt != t0) $display("FAIL nready_trig got %0d want 0", trig_cnt - t0); else n_pass++;
    m_level = 1'b1;
    m_lat   = 3;
    tick(1);
    m_auto = 1'b1;
    n_total++; if ({grant, trigger} !== 3'b011) $display("FAIL nready_grant got grant=%b trig=%b want 01/1", grant, trigger); else n_pass++;
    for (int k = 0; k < 50 && !ack[0]; k++) tick(1);
    n_total++; if (ack !== 2'b01) $display("FAIL nready_ack got %b want 01", ack); else n_pass++;
    req = 2'b00;
    tick(15);
  endtask

  task automatic test_hang();
    int c_ack;
    m_hang = 1'b1;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL hang_pre_err got %b want 0", timeout_err); else n_pass++;
    req = 2'b10;
    for (int k = 0; k < 200 && !ack[1]; k++) tick(1);
    c_ack = cyc;
    req = 2'b00;
    n_total++; if (ack !== 2'b10) $display("FAIL hang_ack got %b want 10", ack); else n_pass++;
    n_total++; if (c_ack - last_trig_cyc != 102) $display("FAIL hang_latency got %0d want 102", c_ack - last_trig_cyc); else n_pass++;
    n_total++; if (timeout_err !== 1'b1) $display("FAIL hang_err got %b want 1", timeout_err); else n_pass++;
    m_auto  = 1'b0;
    m_level = 1'b1;
    m_hang  = 1'b0;
    tick(20);
    n_total++; if ({timeout_err, busy} !== 2'b10) $display("FAIL hang_sticky got err=%b busy=%b want 1/0", timeout_err, busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t0, a0;
    m_auto = 1'b1;
    m_lat  = 2;
    req = 2'b01;
    for (int k = 0; k < 50 && !ack[0]; k++) tick(1);
    req = 2'b00;
    tick(15);
    m_hang = 1'b1;
    t0 = trig_cnt;
    req = 2'b11;
    for (int k = 0; k < 50 && trig_cnt == t0; k++) tick(1);
    n_total++; if (grant !== 2'b10) $display("FAIL rmid_pre_grant got %b want 10", grant); else n_pass++;
    tick(10);
    a0 = ack_cnt;
    n_total++; if (timeout_err !== 1'b1) $display("FAIL rmid_err_sticky got %b want 1", timeout_err); else n_pass++;
    rst     = 1'b1;
    m_auto  = 1'b0;
    m_level = 1'b1;
    #1;
    n_total++; if ({grant, busy, ack} !== 5'b00000) $display("FAIL rmid_ctrl got grant=%b busy=%b ack=%b want 00/0/00", grant, busy, ack); else n_pass++;
    n_total++; if ({ss, command} !== 26'd0) $display("FAIL rmid_data got ss=%h cmd=%h want 0/0", ss, command); else n_pass++;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL rmid_err_clear got %b want 0", timeout_err); else n_pass++;
    tick(2);
    n_total++; if (ack_cnt != a0) $display("FAIL rmid_no_ack got %0d want 0", ack_cnt - a0); else n_pass++;
    m_auto = 1'b1;
    m_hang = 1'b0;
    m_lat  = 2;
    rst    = 1'b0;
    tick(1);
    n_total++; if ({grant, trigger} !== 3'b011) $display("FAIL rmid_rearb got grant=%b trig=%b want 01/1", grant, trigger); else n_pass++;
    for (int k = 0; k < 50 && !ack[0]; k++) tick(1);
    req = 2'b00;
    tick(15);
  endtask

  task automatic test_ignore_change();
    int t0, a0, u0;
    m_lat = 8;
    req_command[15:0] = 16'hA5C3;
    req_ss[9:0]       = 10'h155;
    req_cpol[0]       = 1'b0;
    req_cpha[0]       = 1'b1;
    t0 = trig_cnt;
    a0 = ack_cnt;
    u0 = unstable;
    req = 2'b01;
    for (int k = 0; k < 50 && trig_cnt == t0; k++) tick(1);
    tick(1);
    req_command[15:0] = 16'hFFFF;
    req_ss[9:0]       = 10'h3FF;
    req_cpol[0]       = 1'b1;
    req_cpha[0]       = 1'b0;
    tick(1);
    req = 2'b00;
    for (int k = 0; k < 50 && !ack[0]; k++) tick(1);
    n_total++; if (ack !== 2'b01) $display("FAIL chg_ack got %b want 01", ack); else n_pass++;
    n_total++; if ({command, ss} !== {16'hA5C3, 10'h155}) $display("FAIL chg_data got %h/%h want a5c3/155", command, ss); else n_pass++;
    n_total++; if ({cpol, cpha} !== 2'b01) $display("FAIL chg_mode got %b want 01", {cpol, cpha}); else n_pass++;
    tick(20);
    n_total++; if (ack_cnt - a0 != 1) $display("FAIL chg_ack_once got %0d want 1", ack_cnt - a0); else n_pass++;
    n_total++; if (trig_cnt - t0 != 1) $display("FAIL chg_trig_once got %0d want 1", trig_cnt - t0); else n_pass++;
    n_total++; if (unstable != u0) $display("FAIL chg_stable got %0d want 0", unstable - u0); else n_pass++;
  endtask

  task automatic test_invariants();
    n_total++; if (inv_err != 0) $display("FAIL inv_onehot got %0d want 0", inv_err); else n_pass++;
    n_total++; if (leak != 0) $display("FAIL inv_idle_data got %0d want 0", leak); else n_pass++;
    n_total++; if (unstable != 0) $display("FAIL inv_stable got %0d want 0", unstable); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_not_ready();
    test_hang();
    test_reset_mid();
    test_ignore_change();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
